// File: rtl/twiddle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// twiddle_sequencer_pkg
//   Shared definitions for the radix-4 stage twiddle sequencing:
//   - quarter_e      : which quarter of the stage sub-FFT a sample falls in
//   - TW_MAX_W       : widest sub-FFT index the helper function supports
//   - twiddle_number : maps (quarter, offset) to the twiddle number n
//                      (0, 2k, k, 3k for quarters 0..3), multiplier-free.
// -----------------------------------------------------------------------------
package twiddle_sequencer_pkg;

    localparam int TW_MAX_W = 16;

    typedef enum logic [1:0] {
        QUARTER_0 = 2'd0,
        QUARTER_1 = 2'd1,
        QUARTER_2 = 2'd2,
        QUARTER_3 = 2'd3
    } quarter_e;

    // 3k is formed as 2k + k so no multiplier is inferred.
    function automatic logic [TW_MAX_W-1:0] twiddle_number(
        input quarter_e              q,
        input logic [TW_MAX_W-1:0]   k
    );
        case (q)
            QUARTER_0: return '0;
            QUARTER_1: return k << 1;
            QUARTER_2: return k;
            default:   return (k << 1) + k;
        endcase
    endfunction

endpackage

// File: rtl/flag_delay.sv
// -----------------------------------------------------------------------------
// flag_delay
//   Fixed-depth shift pipeline for a bundle of 1-bit flags.
//   Ports:
//     clock   : rising-edge clock
//     reset   : synchronous active-high reset, clears every stage
//     flags   : WIDTH-bit input bundle
//     delayed : flags delayed exactly DEPTH cycles
// -----------------------------------------------------------------------------
module flag_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] flags,
    output logic [WIDTH-1:0] delayed
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // NOTE: every stage is reset (not just the head) so that samples in flight
    // when reset hits can never emerge afterwards as spurious valids.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= flags;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign delayed = pipe[DEPTH-1];

endmodule

// File: rtl/twiddle_sequencer.sv
// -----------------------------------------------------------------------------
// twiddle_sequencer
//   Generates twiddle table addresses for one FFT stage of sub-FFT size
//   M = 2^LOG_M inside an N = 2^LOG_N point transform, plus the valid,
//   bypass and last flags aligned with the twiddle at the multiplier.
//   Ports:
//     clock     : rising-edge clock
//     reset     : synchronous active-high reset
//     di_en     : input sample valid
//     di_start  : frame realign (only with di_en)
//     tw_addr   : twiddle number scaled to the N-point table (held when idle)
//     tw_req    : tw_addr valid
//     do_en     : tw_req delayed LAT cycles
//     do_bypass : twiddle number is zero, multiplier may be bypassed
//     do_last   : last sample (index M-1) of the stage frame
// -----------------------------------------------------------------------------
module twiddle_sequencer
    import twiddle_sequencer_pkg::*;
#(
    parameter int LOG_N = 6,
    parameter int LOG_M = 6,
    parameter int LAT   = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic             di_start,
    output logic [LOG_N-1:0] tw_addr,
    output logic             tw_req,
    output logic             do_en,
    output logic             do_bypass,
    output logic             do_last
);

    localparam logic [LOG_M-1:0] IDX_LAST = '1;

    logic [LOG_M-1:0]    cnt;
    logic [LOG_M-1:0]    idx;
    logic [LOG_M-1:0]    n;
    logic [TW_MAX_W-1:0] k_ext;
    quarter_e            q;
    logic                tw_bypass;
    logic                tw_last;

    // A realigning sample is index 0 regardless of where the counter was.
    assign idx = di_start ? '0 : cnt;
    assign q   = quarter_e'(idx[LOG_M-1 -: 2]);

    generate
        if (LOG_M > 2) begin : g_offset
            assign k_ext = TW_MAX_W'(idx[LOG_M-3:0]);
        end else begin : g_no_offset
            assign k_ext = '0;
        end
    endgenerate

    // 3k < 3M/4, so the LOG_M-bit truncation never loses information.
    assign n = LOG_M'(twiddle_number(q, k_ext));

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            tw_addr   <= '0;
            tw_req    <= 1'b0;
            tw_bypass <= 1'b0;
            tw_last   <= 1'b0;
        end else begin
            tw_req    <= di_en;
            tw_bypass <= di_en && (n == '0);
            tw_last   <= di_en && (idx == IDX_LAST);
            if (di_en) begin
                cnt     <= idx + LOG_M'(1);
                tw_addr <= LOG_N'(n) << (LOG_N - LOG_M);
            end
        end
    end

    flag_delay #(
        .WIDTH (3),
        .DEPTH (LAT)
    ) u_flag_delay (
        .clock   (clock),
        .reset   (reset),
        .flags   ({tw_req, tw_bypass, tw_last}),
        .delayed ({do_en, do_bypass, do_last})
    );

endmodule

// File: tb/tb_twiddle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_twiddle_sequencer
//   Directed bench for twiddle_sequencer. A main instance (LOG_N=6, LOG_M=6,
//   LAT=2) is checked every cycle against a small reference model; a second
//   instance with LOG_M=4 shares the stimulus and is spot-checked.
// -----------------------------------------------------------------------------
module tb_twiddle_sequencer;

    localparam int LAT = 2;
    localparam int M   = 64;

    logic       clock = 1'b0;
    logic       reset;
    logic       di_en;
    logic       di_start;
    logic [5:0] tw_addr,   tw_addr_b;
    logic       tw_req,    tw_req_b;
    logic       do_en,     do_en_b;
    logic       do_bypass, do_bypass_b;
    logic       do_last,   do_last_b;

    always #5 clock = ~clock;

    twiddle_sequencer #(.LOG_N(6), .LOG_M(6), .LAT(LAT)) dut (
        .clock(clock), .reset(reset), .di_en(di_en), .di_start(di_start),
        .tw_addr(tw_addr), .tw_req(tw_req), .do_en(do_en),
        .do_bypass(do_bypass), .do_last(do_last)
    );

    twiddle_sequencer #(.LOG_N(6), .LOG_M(4), .LAT(LAT)) dut_m4 (
        .clock(clock), .reset(reset), .di_en(di_en), .di_start(di_start),
        .tw_addr(tw_addr_b), .tw_req(tw_req_b), .do_en(do_en_b),
        .do_bypass(do_bypass_b), .do_last(do_last_b)
    );

    int         n_checks = 0;
    int         n_fail   = 0;

    // Reference model state
    int         tb_idx;
    int         last_idx;
    logic [5:0] last_addr;
    logic [2:0] hist [LAT+1];
    int         cycle;
    int         first_do;
    int         do_en_cnt, do_byp_cnt, do_last_cnt, last_at;

    // Twiddle number from index ranges, for M = 64.
    function automatic int exp_n(input int idx);
        if (idx < 16)      return 0;
        else if (idx < 32) return 2 * (idx - 16);
        else if (idx < 48) return idx - 32;
        else               return 3 * (idx - 48);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (time %0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock with the given inputs, then compare all outputs to the model.
    task automatic step(input logic en, input logic start);
        int idx;
        di_en    = en;
        di_start = start;
        idx      = start ? 0 : tb_idx;
        @(posedge clock);
        #1;
        cycle++;
        if (en) begin
            last_addr = 6'(exp_n(idx));
            tb_idx    = (idx + 1) % M;
            last_idx  = idx;
        end
        for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {en, en && (exp_n(idx) == 0), en && (idx == M - 1)};
        check("tw_req",   tw_req,  en);
        check("tw_addr",  tw_addr, last_addr);
        check("do_flags", {do_en, do_bypass, do_last}, hist[LAT]);
        if (do_en) begin
            do_en_cnt++;
            if (first_do < 0) first_do = cycle;
        end
        if (do_bypass) do_byp_cnt++;
        if (do_last) begin
            do_last_cnt++;
            last_at = do_en_cnt;
        end
    endtask

    task automatic do_reset(input logic en);
        reset    = 1'b1;
        di_en    = en;
        di_start = 1'b0;
        @(posedge clock);
        #1;
        check("rst_tw_req",   tw_req,    0);
        check("rst_tw_addr",  tw_addr,   0);
        check("rst_do_flags", {do_en, do_bypass, do_last}, 0);
        check("rst_m4_addr",  tw_addr_b, 0);
        reset       = 1'b0;
        di_en       = 1'b0;
        tb_idx      = 0;
        last_idx    = 0;
        last_addr   = '0;
        for (int i = 0; i <= LAT; i++) hist[i] = '0;
        cycle       = 0;
        first_do    = -1;
        do_en_cnt   = 0;
        do_byp_cnt  = 0;
        do_last_cnt = 0;
        last_at     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        di_en    = 1'b0;
        di_start = 1'b0;

        // Continuous frame straight out of reset.
        do_reset(1'b0);
        for (int s = 0; s < 64; s++) begin
            step(1'b1, 1'b0);
            case (s)
                0:  check("addr_idx0",  tw_addr, 0);
                17: check("addr_idx17", tw_addr, 2);
                35: check("addr_idx35", tw_addr, 3);
                51: check("addr_idx51", tw_addr, 9);
                63: check("addr_idx63", tw_addr, 45);
                5:  check("m4_idx5",  tw_addr_b, 8);
                7:  check("m4_idx7",  tw_addr_b, 24);
                13: check("m4_idx13", tw_addr_b, 12);
                default: ;
            endcase
        end
        for (int s = 0; s < 4; s++) step(1'b0, 1'b0);
        check("cont_first_do",   first_do,    3);
        check("cont_do_en_cnt",  do_en_cnt,   64);
        check("cont_bypass_cnt", do_byp_cnt,  19);
        check("cont_last_cnt",   do_last_cnt, 1);
        check("cont_last_pos",   last_at,     64);

        // Gapped input 1,0,0,1 with ignored di_start on an idle cycle.
        do_reset(1'b0);
        begin
            int accepted = 0;
            int i = 0;
            while (accepted < 64) begin
                logic en;
                en = (i % 4 == 0) || (i % 4 == 3);
                step(en, (i % 4 == 1));
                if (en) accepted++;
                i++;
            end
        end
        for (int s = 0; s < 4; s++) step(1'b0, 1'b0);
        check("gap_do_en_cnt",  do_en_cnt,   64);
        check("gap_bypass_cnt", do_byp_cnt,  19);
        check("gap_last_cnt",   do_last_cnt, 1);

        // Realign at index 20, then again at index 63: both frames truncated.
        do_reset(1'b0);
        for (int s = 0; s < 20; s++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("start_addr", tw_addr, 0);
        for (int s = 0; s < 62; s++) begin
            step(1'b1, 1'b0);
            if (s == 16) check("start_idx17_addr", tw_addr, 2);
        end
        check("pre_start_idx", last_idx, 62);
        step(1'b1, 1'b1);
        for (int s = 0; s < 4; s++) step(1'b0, 1'b0);
        check("trunc_last_cnt",   do_last_cnt, 0);
        check("trunc_bypass_cnt", do_byp_cnt,  37);
        check("trunc_do_en_cnt",  do_en_cnt,   84);

        // Reset at index 40 with di_en high: in-flight samples are discarded.
        do_reset(1'b0);
        for (int s = 0; s < 40; s++) step(1'b1, 1'b0);
        do_reset(1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("post_rst_idx", last_idx, 0);
        for (int s = 0; s < 3; s++) step(1'b0, 1'b0);
        check("post_rst_first_do", first_do, 5);
        for (int s = 0; s < 17; s++) step(1'b1, 1'b0);
        check("post_rst_idx17_addr", tw_addr, 2);
        for (int s = 0; s < 4; s++) step(1'b0, 1'b0);
        check("post_rst_do_en_cnt", do_en_cnt, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
